ghash_msg_feeder: RTL

Packs a stream of 128-bit GHASH input blocks into BLOCK_PROC_PAR-wide (4-lane) words and drives the control interface of the GHASH core. It is the producer side of that interface. It generates valid, message count, bubble count, skip and total-message-count for the core's control signal unit. It then holds off the next frame until the core reports hash done. It sits between the AES-GCM framing logic (AAD/ciphertext/length blocks) and the GHASH core.

---
 rtl/ghash_msg_feeder_if.sv | 37 +++
 rtl/ghash_msg_feeder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ghash_msg_feeder_if.sv
// Bundles the block stream from the GCM framing logic and the control/data
// signals that drive the GHASH core; the feeder uses the slave modport.
interface ghash_msg_feeder_if #(
    parameter int NB_BLOCK            = 128,
    parameter int NB_N_MESSAGES       = 10,
    parameter int LOG2_BLOCK_PROC_PAR = 2
);
    localparam int BLOCK_PROC_PAR = 1 << LOG2_BLOCK_PROC_PAR;

    logic                               i_start;
    logic [NB_N_MESSAGES:0]             i_rf_n_messages;
    logic [NB_BLOCK-1:0]                i_block;
    logic                               i_block_valid;
    logic                               i_block_last;
    logic                               o_block_ready;
    logic                               i_hash_done;
    logic [BLOCK_PROC_PAR*NB_BLOCK-1:0] o_data_x;
    logic                               o_valid;
    logic [NB_N_MESSAGES-1:0]           o_msg_count;
    logic [NB_N_MESSAGES:0]             o_n_messages;
    logic [LOG2_BLOCK_PROC_PAR-1:0]     o_msg_bubbles;
    logic                               o_skip_bus;
    logic                               o_busy;
    logic                               o_len_error;

    modport slave (
        input  i_start, i_rf_n_messages, i_block, i_block_valid, i_block_last, i_hash_done,
        output o_block_ready, o_data_x, o_valid, o_msg_count, o_n_messages,
               o_msg_bubbles, o_skip_bus, o_busy, o_len_error
    );

    modport master (
        output i_start, i_rf_n_messages, i_block, i_block_valid, i_block_last, i_hash_done,
        input  o_block_ready, o_data_x, o_valid, o_msg_count, o_n_messages,
               o_msg_bubbles, o_skip_bus, o_busy, o_len_error
    );
endinterface

// File: rtl/ghash_msg_feeder.sv
// Packs 128-bit GHASH blocks into 4-lane words with leading zero bubbles and
// drives the GHASH core control. Optional macro: GHASH_FEEDER_LEN_CHECK_EN.
module ghash_msg_feeder #(
    parameter int NB_BLOCK            = 128,
    parameter int NB_N_MESSAGES       = 10,
    parameter int LOG2_BLOCK_PROC_PAR = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    ghash_msg_feeder_if.slave   io_feeder
);
    localparam int BLOCK_PROC_PAR = 1 << LOG2_BLOCK_PROC_PAR;
    localparam int NB_WORD        = BLOCK_PROC_PAR * NB_BLOCK;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FILL      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [LOG2_BLOCK_PROC_PAR-1:0] PTR_LAST = '1;
    localparam logic [NB_N_MESSAGES-1:0]       MSG_STEP = NB_N_MESSAGES'(BLOCK_PROC_PAR);

    logic [1:0]                     r_state;
    logic [NB_N_MESSAGES:0]         r_n;
    logic [NB_N_MESSAGES:0]         r_cnt;
    logic [LOG2_BLOCK_PROC_PAR-1:0] r_ptr;
    logic [LOG2_BLOCK_PROC_PAR-1:0] r_bubbles;
    logic [NB_BLOCK-1:0]            r_lane [BLOCK_PROC_PAR];
    logic [NB_WORD-1:0]             r_data_x;
    logic                           r_valid;
    logic                           r_skip;
    logic                           r_ready;
    logic                           r_busy;
    logic [NB_N_MESSAGES-1:0]       r_msg_count;

    logic                           w_accept;
    logic [NB_N_MESSAGES:0]         w_cnt_next;
    logic [LOG2_BLOCK_PROC_PAR-1:0] w_bubbles;
    logic [NB_WORD-1:0]             w_packed;

    assign w_accept   = (r_state == ST_FILL) && r_ready && io_feeder.i_block_valid;
    assign w_cnt_next = r_cnt + 1'b1;
    // Leading bubbles pad the frame so its last block always lands in lane 3.
    assign w_bubbles  = ~io_feeder.i_rf_n_messages[LOG2_BLOCK_PROC_PAR-1:0] + 1'b1;

    // Word as it will look once the incoming block lands in the current lane.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_PROC_PAR; gi++) begin : g_lane
            assign w_packed[(BLOCK_PROC_PAR-gi)*NB_BLOCK-1 -: NB_BLOCK] =
                (r_ptr == LOG2_BLOCK_PROC_PAR'(gi)) ? io_feeder.i_block : r_lane[gi];
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_bubbles   <= '0;
            r_data_x    <= '0;
            r_valid     <= 1'b0;
            r_skip      <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_msg_count <= '0;
            for (int i = 0; i < BLOCK_PROC_PAR; i++) r_lane[i] <= '0;
        end else begin
            r_valid <= 1'b0;
            r_skip  <= 1'b0;
            if (r_valid) r_msg_count <= r_msg_count + MSG_STEP;

            case (r_state)
                ST_IDLE: begin
                    if (io_feeder.i_start) begin
                        r_n         <= io_feeder.i_rf_n_messages;
                        r_bubbles   <= w_bubbles;
                        r_ptr       <= w_bubbles;
                        r_cnt       <= '0;
                        r_msg_count <= '0;
                        r_busy      <= 1'b1;
                        for (int i = 0; i < BLOCK_PROC_PAR; i++) r_lane[i] <= '0;
                        if (io_feeder.i_rf_n_messages == '0) begin
                            r_data_x <= '0;
                            r_valid  <= 1'b1;
                            r_skip   <= 1'b1;
                            r_state  <= ST_WAIT_DONE;
                        end else begin
                            r_ready  <= 1'b1;
                            r_state  <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_lane[r_ptr] <= io_feeder.i_block;
                        r_ptr         <= r_ptr + 1'b1;
                        r_cnt         <= w_cnt_next;
                        if (r_ptr == PTR_LAST) begin
                            r_data_x <= w_packed;
                            r_valid  <= 1'b1;
                        end
                        if (w_cnt_next == r_n) begin
                            r_ready <= 1'b0;
                            r_state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (io_feeder.i_hash_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GHASH_FEEDER_LEN_CHECK_EN
    logic r_len_error;

    // Flags a last marker on the wrong block or a missing one on block n.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_len_error <= 1'b0;
        end else if ((r_state == ST_IDLE) && io_feeder.i_start) begin
            r_len_error <= 1'b0;
        end else if (w_accept && (io_feeder.i_block_last != (w_cnt_next == r_n))) begin
            r_len_error <= 1'b1;
        end
    end

    assign io_feeder.o_len_error = r_len_error;
`else
    assign io_feeder.o_len_error = 1'b0;
`endif

    assign io_feeder.o_block_ready = r_ready;
    assign io_feeder.o_data_x      = r_data_x;
    assign io_feeder.o_valid       = r_valid;
    assign io_feeder.o_msg_count   = r_msg_count;
    assign io_feeder.o_n_messages  = r_n;
    assign io_feeder.o_msg_bubbles = r_bubbles;
    assign io_feeder.o_skip_bus    = r_skip;
    assign io_feeder.o_busy        = r_busy;
endmodule
